// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath (forward filter and inverse filter).
//   fir_state_e : state encoding of the iterative inverse-filter FSM
//   k_arr_t     : coefficient array type sized for the largest supported order
//   sat_t       : saturation result (value plus overflow flag)
//   fir_w_y()   : output width of an order-n FIR with w_x-bit data, w_k-bit taps
//   sat_signed(): clamp a wide signed accumulator into w_x signed bits
package fir_pkg;

    localparam int MAX_N   = 16;
    localparam int MAX_W_K = 16;

    typedef logic signed [MAX_W_K-1:0] k_arr_t [MAX_N+1];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    typedef struct packed {
        logic signed [31:0] value;
        logic               ovf;
    } sat_t;

    function automatic int fir_w_y(input int w_x, input int w_k, input int n);
        return w_x + w_k + $clog2(n);
    endfunction

    // Clamp acc into the signed w_x-bit range; ovf flags that clamping happened.
    function automatic sat_t sat_signed(input logic signed [63:0] acc, input int w_x);
        sat_t   r;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w_x - 1)) - 1;
        lo = -(longint'(1) <<< (w_x - 1));
        if (acc > hi) begin
            r.value = 32'(hi);
            r.ovf   = 1'b1;
        end else if (acc < lo) begin
            r.value = 32'(lo);
            r.ovf   = 1'b1;
        end else begin
            r.value = 32'(acc);
            r.ovf   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_inverse_filter_delay_line.sv
// History of reconstructed samples for the inverse filter.
//   clk, rst  : clock, asynchronous active-high clear of every entry
//   shift_en  : push din into entry 0, older entries move one place deeper
//   din       : newest reconstructed sample
//   rd_idx    : entry to read (0 = most recent sample)
//   rd_data   : combinational read of hist[rd_idx]
module fir_delay_line #(
    parameter int N     = 3,
    parameter int W_X   = 4,
    parameter int W_IDX = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic signed [W_X-1:0]   din,
    input  logic        [W_IDX-1:0] rd_idx,
    output logic signed [W_X-1:0]   rd_data
);

    logic signed [W_X-1:0] hist [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                hist[j] <= '0;
            end
        end else if (shift_en) begin
            hist[0] <= din;
            for (int j = 1; j < N; j++) begin
                hist[j] <= hist[j-1];
            end
        end
    end

    assign rd_data = hist[rd_idx];

endmodule

// File: rtl/fir_inverse_filter.sv
// Iterative streaming deconvolver: x[n] = sat(y[n] - sum_{i=1..N} K[i]*x[n-i]).
// One coefficient is consumed per cycle; K[0] is the implied unity tap.
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; valid never depends combinationally on ready, and a
// producer keeps its data stable while valid is high and ready is low.
//   clk, rst         : clock, asynchronous active-high reset
//   s_valid/s_ready  : input sample handshake (s_ready only in IDLE, 0 in reset)
//   s_y              : signed FIR output sample
//   m_valid/m_ready  : reconstructed sample handshake
//   m_x, m_ovf       : saturated reconstructed sample and its saturation flag
//   state            : current FSM state, for observation
module fir_inverse_filter
    import fir_pkg::*;
#(
    parameter int N   = 3,
    parameter int W_X = 4,
    parameter int W_K = 4,
    parameter int W_Y = fir_w_y(W_X, W_K, N),
    parameter logic signed [W_K-1:0] K [N+1] = '{4'sd1, 4'sd2, 4'sd3, 4'sd4}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [W_Y-1:0] s_y,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_X-1:0] m_x,
    output logic                  m_ovf,
    output fir_state_e            state
);

    localparam int W_ACC = W_Y + 2;
    localparam int W_P   = W_X + W_K;
    localparam int W_I   = $clog2(N + 1);
    localparam int W_IDX = (N > 1) ? $clog2(N) : 1;

    if (int'(K[0]) != 1) begin : g_bad_k0
        $error("fir_inverse_filter: K[0] must be 1");
    end

    fir_state_e              state_q, state_d;
    logic signed [W_ACC-1:0] acc;
    logic        [W_I-1:0]   i;
    logic signed [W_X-1:0]   hist_rd;
    logic signed [W_P-1:0]   prod;
    logic signed [W_ACC-1:0] acc_next;
    sat_t                    sat_res;
    logic                    accept;
    logic                    xfer;
    logic                    last_tap;
    logic                    unused_sat_bits;

    assign s_ready  = (state_q == ST_IDLE) && !rst;
    assign m_valid  = (state_q == ST_OUT);
    assign accept   = s_valid && s_ready;
    assign xfer     = m_valid && m_ready;
    assign last_tap = (i == W_I'(N));
    assign state    = state_q;

    // Both factors are widened before multiplying so the full product is kept.
    assign prod     = W_P'(K[i]) * W_P'(hist_rd);
    assign acc_next = acc - W_ACC'(prod);
    assign sat_res  = sat_signed(64'(acc_next), W_X);

    // Only the low W_X bits of the clamped value are meaningful.
    assign unused_sat_bits = ^sat_res.value[31:W_X];

    fir_delay_line #(
        .N     (N),
        .W_X   (W_X),
        .W_IDX (W_IDX)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (xfer),
        .din      (m_x),
        .rd_idx   (W_IDX'(i - W_I'(1))),
        .rd_data  (hist_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_MAC;
            ST_MAC:  if (last_tap) state_d = ST_OUT;
            ST_OUT:  if (xfer)     state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            i     <= W_I'(1);
            m_x   <= '0;
            m_ovf <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        acc <= W_ACC'(s_y);
                        i   <= W_I'(1);
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    if (last_tap) begin
                        // Result is captured on the same edge as the final tap.
                        m_x   <= sat_res.value[W_X-1:0];
                        m_ovf <= sat_res.ovf;
                    end else begin
                        i <= i + W_I'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_inverse_filter.sv
module tb_fir_inverse_filter;
    import fir_pkg::*;

    localparam int N   = 3;
    localparam int W_X = 4;
    localparam int W_K = 4;
    localparam int W_Y = W_X + W_K + $clog2(N);
    localparam logic signed [W_K-1:0] K_TB [N+1] = '{4'sd1, 4'sd2, 4'sd3, 4'sd4};

    int kk [N+1] = '{1, 2, 3, 4};

    logic                  clk;
    logic                  rst;
    logic                  s_valid;
    logic                  s_ready;
    logic signed [W_Y-1:0] s_y;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [W_X-1:0] m_x;
    logic                  m_ovf;
    fir_state_e            state;

    fir_inverse_filter #(
        .N   (N),
        .W_X (W_X),
        .W_K (W_K),
        .W_Y (W_Y),
        .K   (K_TB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_y     (s_y),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_x     (m_x),
        .m_ovf   (m_ovf),
        .state   (state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int          errors = 0;
    int          checks = 0;
    logic [W_X:0] exp_q[$];
    int          rise_q[$];
    int          n_xfer = 0;
    logic        mv_prev = 1'b0;
    logic [W_X:0] exp_v;
    bit          rand_ready = 0;

    // reference-model history: decoded samples and original samples, newest first
    int dec_hist[$];
    int src_hist[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && !mv_prev) rise_q.push_back(cyc);
            if (m_valid && m_ready) begin
                n_xfer++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got x=%0d ovf=%0d, expected no output",
                             $signed(m_x), m_ovf);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({m_ovf, m_x} !== exp_v) begin
                        errors++;
                        $display("FAIL sample: got x=%0d ovf=%0d, expected x=%0d ovf=%0d",
                                 $signed(m_x), m_ovf, $signed(exp_v[W_X-1:0]), exp_v[W_X]);
                    end
                end
            end
        end
        mv_prev = m_valid;
    end

    // ---------------- reference model ----------------
    // Inverse filter straight from its definition: x = sat(y - sum K[i]*x[n-i]).
    task automatic expect_decode(input int y);
        int acc;
        int x;
        logic ovf;
        logic [W_X-1:0] xb;
        acc = y;
        for (int k = 1; k <= N; k++) begin
            if (k - 1 < dec_hist.size()) acc = acc - kk[k] * dec_hist[k-1];
        end
        if (acc > 7) begin
            x = 7; ovf = 1'b1;
        end else if (acc < -8) begin
            x = -8; ovf = 1'b1;
        end else begin
            x = acc; ovf = 1'b0;
        end
        dec_hist.push_front(x);
        if (dec_hist.size() > N) void'(dec_hist.pop_back());
        xb = x[W_X-1:0];
        exp_q.push_back({ovf, xb});
    endtask

    // Golden forward FIR: y = sum_{i=0..N} K[i]*x[n-i].
    function automatic int fir_forward(input int x);
        int y;
        src_hist.push_front(x);
        if (src_hist.size() > N + 1) void'(src_hist.pop_back());
        y = 0;
        for (int k = 0; k < src_hist.size(); k++) y = y + kk[k] * src_hist[k];
        return y;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_sample(input int y, output int accept_edge);
        bit got;
        got = 0;
        s_y = y[W_Y-1:0];
        s_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (s_ready) begin
                got = 1;
                break;
            end
            tick();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got s_ready=0, expected 1 within 300 cycles");
        end
        tick();
        accept_edge = cyc;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 2000) begin
            tick();
            k++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_s_ready", int'(s_ready), 0);
        tick();
        tick();
        check("reset_m_x", int'(m_x), 0);
        check("reset_m_ovf", int'(m_ovf), 0);
        check("reset_state", int'(state), int'(ST_IDLE));
        exp_q.delete();
        dec_hist.delete();
        src_hist.delete();
        rst = 1'b0;
        tick();
        check("post_reset_s_ready", int'(s_ready), 1);
    endtask

    // ---------------- stimulus ----------------
    int acc_edges[4];
    int ae;
    int x_in;
    int y_in;
    int cap_x;
    int cap_ovf;
    int bad_stable;
    int bad_ready;
    int bad_valid;
    int x0;
    int waited;

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_y = '0;
        m_ready = 1'b0;
        apply_reset();

        // impulse: y = 1,2,3,4 decodes to x = 1,0,0,0
        m_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            expect_decode(k);
            send_sample(k, ae);
        end
        drain();

        // latency and throughput with m_ready held high
        rise_q.delete();
        for (int k = 0; k < 4; k++) begin
            y_in = int'($urandom_range(0, 40)) - 20;
            expect_decode(y_in);
            send_sample(y_in, ae);
            acc_edges[k] = ae;
        end
        drain();
        tick();
        check("rise_count", rise_q.size(), 4);
        if (rise_q.size() == 4) begin
            for (int k = 0; k < 4; k++) check("latency", rise_q[k] - acc_edges[k], N);
        end
        for (int k = 1; k < 4; k++) check("accept_period", acc_edges[k] - acc_edges[k-1], N + 2);

        // backpressure: hold m_ready low for 20 cycles in OUT
        m_ready = 1'b0;
        y_in = int'($urandom_range(0, 30)) - 15;
        expect_decode(y_in);
        send_sample(y_in, ae);
        waited = 0;
        while (!m_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("bp_m_valid", int'(m_valid), 1);
        cap_x = int'(m_x);
        cap_ovf = int'(m_ovf);
        bad_stable = 0;
        bad_ready = 0;
        bad_valid = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (int'(m_x) != cap_x || int'(m_ovf) != cap_ovf) bad_stable++;
            if (s_ready) bad_ready++;
            if (!m_valid) bad_valid++;
        end
        check("bp_stable", bad_stable, 0);
        check("bp_s_ready_low", bad_ready, 0);
        check("bp_valid_held", bad_valid, 0);
        x0 = n_xfer;
        m_ready = 1'b1;
        repeat (6) tick();
        check("bp_one_transfer", n_xfer - x0, 1);
        check("bp_idle_s_ready", int'(s_ready), 1);
        check("bp_idle_m_valid", int'(m_valid), 0);
        drain();

        // saturation right after reset: y=9 -> 7/ovf, then y=0 -> -8/ovf
        apply_reset();
        m_ready = 1'b1;
        expect_decode(9);
        send_sample(9, ae);
        expect_decode(0);
        send_sample(0, ae);
        drain();

        // reset during MAC discards the sample and clears history
        apply_reset();
        m_ready = 1'b1;
        expect_decode(1);
        send_sample(1, ae);
        drain();
        repeat (2) tick();
        send_sample(5, ae);
        tick();
        check("midmac_state", int'(state), int'(ST_MAC));
        x0 = n_xfer;
        apply_reset();
        repeat (8) tick();
        check("midmac_no_output", n_xfer - x0, 0);
        check("midmac_m_valid", int'(m_valid), 0);
        expect_decode(5);
        send_sample(5, ae);
        drain();

        // random loopback through the golden forward FIR
        apply_reset();
        rand_ready = 1;
        for (int k = 0; k < 200; k++) begin
            logic [W_X-1:0] xb;
            x_in = int'($urandom_range(0, 15)) - 8;
            y_in = fir_forward(x_in);
            xb = x_in[W_X-1:0];
            exp_q.push_back({1'b0, xb});
            repeat ($urandom_range(0, 2)) tick();
            send_sample(y_in, ae);
        end
        drain();
        rand_ready = 0;
        m_ready = 1'b1;
        repeat (4) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
